// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Holds MdOpE operation codes and the sequencer FSM state codes.
package muldiv_pkg;

    // MdOpE encodings: bit 1 selects divide, bit 0 selects unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// Ports: isDiv selects the step; aIn/bIn/cIn are the sequencer's working
// registers, aOut/bOut/cOut their values after this iteration.
//   multiply: a = product, b = shifted multiplicand, c = remaining multiplier
//   divide:   a = partial remainder (low W+1 bits), b = divisor, c = quotient
module muldiv_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      isDiv,
    input  logic [2*DATA_WIDTH-1:0]   aIn,
    input  logic [2*DATA_WIDTH-1:0]   bIn,
    input  logic [DATA_WIDTH-1:0]     cIn,
    output logic [2*DATA_WIDTH-1:0]   aOut,
    output logic [2*DATA_WIDTH-1:0]   bOut,
    output logic [DATA_WIDTH-1:0]     cOut
);

    localparam int W = DATA_WIDTH;

    logic [W:0] remShift;
    logic [W:0] remDiff;

    // Partial remainder is always below the divisor, so after the shift it
    // fits in W+1 bits and bit W of the difference is a clean borrow flag.
    assign remShift = {aIn[W-1:0], cIn[W-1]};
    assign remDiff  = remShift - {1'b0, bIn[W-1:0]};

    always_comb begin
        aOut = aIn;
        bOut = bIn;
        cOut = cIn;
        if (isDiv) begin
            if (!remDiff[W]) begin
                aOut = {{(W-1){1'b0}}, remDiff};
                cOut = {cIn[W-2:0], 1'b1};
            end else begin
                aOut = {{(W-1){1'b0}}, remShift};
                cOut = {cIn[W-2:0], 1'b0};
            end
        end else begin
            if (cIn[0]) begin
                aOut = aIn + bIn;
            end
            bOut = bIn << 1;
            cOut = cIn >> 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller driving the HI/LO registers.
// Inputs: clk, rst (sync, active high), StartE, MdOpE, SrcAE, SrcBE,
// HiLoReadD. Outputs: StallMD, BusyMD, DoneMD, DivZeroMD, HiOut, LoOut.
// Optional: define MULDIV_EARLY_TERM_EN to end a multiply as soon as the
// remaining multiplier bits are all zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StartE,
    input  logic [1:0]            MdOpE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic                  HiLoReadD,
    output logic                  StallMD,
    output logic                  BusyMD,
    output logic                  DoneMD,
    output logic                  DivZeroMD,
    output logic [DATA_WIDTH-1:0] HiOut,
    output logic [DATA_WIDTH-1:0] LoOut
);

    localparam int W = DATA_WIDTH;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] iterCnt;
    logic [2*W-1:0]       regA;
    logic [2*W-1:0]       regB;
    logic [W-1:0]         regC;
    logic                 opIsDiv;
    logic                 negResult;
    logic                 negDividend;
    logic                 divZero;

    logic [2*W-1:0]       nextA;
    logic [2*W-1:0]       nextB;
    logic [W-1:0]         nextC;

    logic                 startDiv;
    logic                 srcANeg;
    logic                 srcBNeg;
    logic [W-1:0]         absA;
    logic [W-1:0]         absB;
    logic                 lastIter;

    logic [2*W-1:0]       prodFix;
    logic [W-1:0]         quoFix;
    logic [W-1:0]         remRaw;
    logic [W-1:0]         remFix;

    muldiv_core #(
        .DATA_WIDTH (W)
    ) uCore (
        .isDiv (opIsDiv),
        .aIn   (regA),
        .bIn   (regB),
        .cIn   (regC),
        .aOut  (nextA),
        .bOut  (nextB),
        .cOut  (nextC)
    );

    // Operand conditioning: signed ops work on magnitudes
    assign startDiv = isDivOp(MdOpE);
    assign srcANeg  = isSignedOp(MdOpE) & SrcAE[W-1];
    assign srcBNeg  = isSignedOp(MdOpE) & SrcBE[W-1];
    assign absA     = srcANeg ? (-SrcAE) : SrcAE;
    assign absB     = srcBNeg ? (-SrcBE) : SrcBE;

`ifdef MULDIV_EARLY_TERM_EN
    assign lastIter = (iterCnt == CNT_WIDTH'(W - 1)) |
                      (!opIsDiv && (nextC == '0));
`else
    assign lastIter = (iterCnt == CNT_WIDTH'(W - 1));
`endif

    // Sign fix-up applied in DONE
    assign prodFix = negResult ? (-regA) : regA;
    assign quoFix  = negResult ? (-regC) : regC;
    assign remRaw  = regA[W-1:0];
    assign remFix  = negDividend ? (-remRaw) : remRaw;

    assign BusyMD  = (state != ST_IDLE);
    assign StallMD = BusyMD & (StartE | HiLoReadD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            iterCnt     <= '0;
            regA        <= '0;
            regB        <= '0;
            regC        <= '0;
            opIsDiv     <= 1'b0;
            negResult   <= 1'b0;
            negDividend <= 1'b0;
            divZero     <= 1'b0;
            DoneMD      <= 1'b0;
            DivZeroMD   <= 1'b0;
            HiOut       <= '0;
            LoOut       <= '0;
        end else begin
            DoneMD <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (StartE) begin
                        iterCnt     <= '0;
                        opIsDiv     <= startDiv;
                        negResult   <= srcANeg ^ srcBNeg;
                        negDividend <= srcANeg;
                        if (startDiv && (SrcBE == '0)) begin
                            // Divide by zero skips RUN; DONE writes these
                            // raw values straight to HI/LO.
                            state     <= ST_DONE;
                            divZero   <= 1'b1;
                            DivZeroMD <= 1'b1;
                            regA      <= {{W{1'b0}}, SrcAE};
                            regB      <= '0;
                            regC      <= '1;
                        end else begin
                            state   <= ST_RUN;
                            divZero <= 1'b0;
                            regA    <= '0;
                            if (startDiv) begin
                                DivZeroMD <= 1'b0;
                                regB      <= {{W{1'b0}}, absB};
                                regC      <= absA;
                            end else begin
                                regB <= {{W{1'b0}}, absA};
                                regC <= absB;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    regA    <= nextA;
                    regB    <= nextB;
                    regC    <= nextC;
                    iterCnt <= iterCnt + 1'b1;
                    if (lastIter) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    DoneMD <= 1'b1;
                    if (divZero) begin
                        HiOut <= regA[W-1:0];
                        LoOut <= regC;
                    end else if (opIsDiv) begin
                        HiOut <= remFix;
                        LoOut <= quoFix;
                    end else begin
                        HiOut <= prodFix[2*W-1:W];
                        LoOut <= prodFix[W-1:0];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: spec vectors, stall/reset
// sequences and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiLoReadD;
    logic        StallMD;
    logic        BusyMD;
    logic        DoneMD;
    logic        DivZeroMD;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .StartE    (StartE),
        .MdOpE     (MdOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .HiLoReadD (HiLoReadD),
        .StallMD   (StallMD),
        .BusyMD    (BusyMD),
        .DoneMD    (DoneMD),
        .DivZeroMD (DivZeroMD),
        .HiOut     (HiOut),
        .LoOut     (LoOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Cycle (counted from the accept edge) at which DoneMD is expected
    function automatic int expLat(input logic [1:0] op,
                                  input logic [31:0] b);
        if (op[1] && b == 32'd0) return 2;
`ifdef MULDIV_EARLY_TERM_EN
        if (!op[1]) begin
            logic [31:0] m;
            int n;
            m = (op == OP_MULT && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return n + 2;
        end
`endif
        return 34;
    endfunction

    // Plain-arithmetic reference for HI/LO and the sticky div-zero flag
    task automatic model(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, inout logic dz,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    dz = 1'b0;
                    if (op == OP_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                        hi = r[31:0];
                        lo = q[31:0];
                    end else begin
                        hi = a % b;
                        lo = a / b;
                    end
                end
            end
        endcase
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        StartE = 1'b1;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        @(posedge clk);
        #1 StartE = 1'b0;
    endtask

    // Called right after the accept edge; watches BusyMD and DoneMD
    task automatic waitDone(input string nm, input logic [31:0] eHi,
                            input logic [31:0] eLo, input logic eDz,
                            input int eLat);
        bit seen = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (DoneMD) begin
                seen = 1;
                chk({nm, " latency"}, 64'(k), 64'(eLat));
                chk({nm, " hi"}, {32'd0, HiOut}, {32'd0, eHi});
                chk({nm, " lo"}, {32'd0, LoOut}, {32'd0, eLo});
                chk({nm, " divzero"}, {63'd0, DivZeroMD}, {63'd0, eDz});
                chk({nm, " busy@done"}, {63'd0, BusyMD}, 64'd0);
            end else if (k < eLat) begin
                chk({nm, " busy"}, {63'd0, BusyMD}, 64'd1);
            end
        end
        if (!seen) chk({nm, " timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        chk({nm, " done pulse"}, {63'd0, DoneMD}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        logic        mDz;
        logic [31:0] mHi, mLo;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          eLat;

        vecs[0] = '{"multu max", OP_MULTU, 32'hFFFF_FFFF, 32'd2,
                    32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{"mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5,
                    32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{"div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{"divu by0", OP_DIVU, 32'h0000_1234, 32'd0,
                    32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"multu sticky", OP_MULTU, 32'd6, 32'd7,
                    32'd0, 32'd42, 1'b1};
        vecs[6] = '{"divu 9/3", OP_DIVU, 32'd9, 32'd3,
                    32'd0, 32'd3, 1'b0};
        vecs[7] = '{"div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
                    32'd1, 32'hFFFF_FFFD, 1'b0};

        rst = 1'b1;
        StartE = 1'b0;
        MdOpE = 2'b00;
        SrcAE = '0;
        SrcBE = '0;
        HiLoReadD = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {63'd0, BusyMD}, 64'd0);
        chk("reset done", {63'd0, DoneMD}, 64'd0);
        chk("reset dz", {63'd0, DivZeroMD}, 64'd0);
        chk("reset stall", {63'd0, StallMD}, 64'd0);
        chk("reset hilo", {HiOut, LoOut}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(vecs[i].nm, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                     expLat(vecs[i].op, vecs[i].b));
        end

        // MFHI/MFLO in Decode from cycle 5 stalls until IDLE
        eLat = expLat(OP_MULT, 32'd7);
        launch(OP_MULT, 32'd6, 32'd7);
        for (int k = 1; k <= eLat; k++) begin
            @(negedge clk);
            if (k == 5) HiLoReadD = 1'b1;
            #1;
            chk($sformatf("rd stall c%0d", k), {63'd0, StallMD},
                {63'd0, (k >= 5 && k < eLat)});
        end
        chk("rd done", {63'd0, DoneMD}, 64'd1);
        chk("rd hilo", {HiOut, LoOut}, 64'd42);
        HiLoReadD = 1'b0;

        // Second op arrives at cycle 2, held until accepted
        eLat = expLat(OP_MULT, 32'hFFFF_FFFF);
        launch(OP_MULT, 32'd5, 32'hFFFF_FFFF);
        for (int k = 1; k <= eLat; k++) begin
            @(negedge clk);
            if (k == 2) begin
                StartE = 1'b1;
                MdOpE  = OP_MULTU;
                SrcAE  = 32'd3;
                SrcBE  = 32'd4;
            end
            #1;
            chk($sformatf("b2b stall c%0d", k), {63'd0, StallMD},
                {63'd0, (k >= 2 && k < eLat)});
        end
        chk("b2b first", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFB);
        @(posedge clk);
        #1 StartE = 1'b0;
        waitDone("b2b second", 32'd0, 32'd12, 1'b0,
                 expLat(OP_MULTU, 32'd4));

        // Reset during a divide discards it
        launch(OP_DIV, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst busy", {63'd0, BusyMD}, 64'd0);
        chk("rst hilo", {HiOut, LoOut}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (DoneMD) chk("rst no done", 64'd1, 64'd0);
        end
        chk("rst quiet", {62'd0, DoneMD, BusyMD}, 64'd0);

        mDz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            model(rop, ra, rb, mDz, mHi, mLo);
            launch(rop, ra, rb);
            waitDone($sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb),
                     mHi, mLo, mDz, expLat(rop, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
